// File: rtl/prog_loader_if.sv
// Bus bundle between the program loader, its source ROM, the program memory
// and the CPU core control lines.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   load_count;

  // Loader side
  modport slave (
    input  start, rom_data,
    output rom_addr, mem_we, mem_addr, mem_wdata,
           core_reset, busy, done, load_count
  );

  // Environment side (ROM, memory, controller)
  modport master (
    output start, rom_data,
    input  rom_addr, mem_we, mem_addr, mem_wdata,
           core_reset, busy, done, load_count
  );
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: copies ROM_DEPTH words from a synchronous ROM
// (1-cycle read latency) into program memory while holding the CPU core in
// reset, then releases the core. A rising edge of start in DONE reloads.
module prog_loader #(
  parameter int ROM_DEPTH = 256,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  prog_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(ROM_DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);

  state_t            state;
  logic              start_q;
  logic              start_armed;
  logic              start_edge;
  logic [ADDR_W-1:0] rom_addr;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   load_count;

  // Saturating word counter so the count parks at ROM_DEPTH.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // start_armed only goes high once start has been seen low, so a level held
  // high across reset release never counts as a request.
  assign start_edge = bus.start & ~start_q & start_armed;

  // Control FSM, ROM read stage (p0) and one-cycle-delayed write stage (p1).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      start_armed <= ~bus.start;
      rom_addr    <= '0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      core_reset  <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      load_count  <= '0;
    end else begin
      start_q     <= bus.start;
      start_armed <= start_armed | ~bus.start;

      // p0 -> p1: the word read in a LOAD cycle is written on the next cycle
      vld_p1  <= (state == LOAD);
      addr_p1 <= rom_addr;
      if (vld_p1) begin
        load_count <= sat_inc(load_count);
      end

      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state      <= LOAD;
            rom_addr   <= '0;
            load_count <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        LOAD: begin
          if (rom_addr == LAST_ADDR) begin
            state <= DRAIN;
          end else begin
            rom_addr <= rom_addr + ADDR_ONE;
          end
        end
        DRAIN: begin
          state      <= DONE;
          busy       <= 1'b0;
          done       <= 1'b1;
          core_reset <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = rom_addr;
  assign bus.mem_we     = vld_p1;
  assign bus.mem_addr   = addr_p1;
  assign bus.mem_wdata  = vld_p1 ? bus.rom_data : {DATA_W{1'b0}};
  assign bus.core_reset = core_reset;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.load_count = load_count;

endmodule
